// File: rtl/inst_arbiter_if.sv
// Request/grant bundle between the shared-resource arbiter and its child instances.
// master = requester side, slave = arbiter side.
interface inst_arbiter_if #(
  parameter int unsigned N_REQ = 5
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [2:0]       gnt_id;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/inst_arbiter.sv
// Round-robin arbiter granting one child instance at a time, with a hold timeout
// and a mandatory one-cycle release gap between grants.
module inst_arbiter #(
  parameter int unsigned N_REQ   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_arbiter_if.slave bus
);

  localparam int unsigned     TmrW   = $clog2(TIMEOUT);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [2:0]       gnt_id_q;
  logic [2:0]       ptr_q;
  logic             busy_q;
  logic             terr_q;
  logic [TmrW-1:0]  timer_q;

  logic             sel_found;
  logic [2:0]       sel_id;
  logic [N_REQ-1:0] sel_gnt;
  int unsigned      idx;

  // First requester at or after ptr_q, wrapping past N_REQ-1.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_gnt   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!sel_found && bus.req[idx]) begin
        sel_found    = 1'b1;
        sel_id       = 3'(idx);
        sel_gnt      = '0;
        sel_gnt[idx] = 1'b1;
      end
    end
  end

  // Only the granted bit of req/done matters while a grant is held.
  logic       cur_done;
  logic       cur_req;
  logic       at_limit;
  logic [2:0] ptr_nxt;

  assign cur_done = |(bus.done & gnt_q);
  assign cur_req  = |(bus.req & gnt_q);
  assign at_limit = (timer_q == TmrMax);
  assign ptr_nxt  = (32'(gnt_id_q) == N_REQ - 1) ? 3'd0 : gnt_id_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            state_q  <= StGrant;
            gnt_q    <= sel_gnt;
            gnt_id_q <= sel_id;
            busy_q   <= 1'b1;
            timer_q  <= '0;
          end
        end
        StGrant: begin
          if (cur_done || !cur_req || at_limit) begin
            state_q  <= StRelease;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= ptr_nxt;
            // A completion on the final cycle counts as a normal finish.
            terr_q   <= at_limit && !cur_done;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRelease: begin
          state_q <= StIdle;
          terr_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          gnt_q    <= '0;
          gnt_id_q <= '0;
          busy_q   <= 1'b0;
          terr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: doc/inst_arbiter.md
INST_ARBITER -- requirements
Module: inst_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 5, the number of child instances (requesters) sharing the resource.
REQ-002 SHALL provide parameter TIMEOUT, default 16, the maximum number of consecutive cycles one grant may be held (legal range 2..255).
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port req  input  N_REQ  per-instance request level; bit i belongs to inst_i.
REQ-006 SHALL provide port done  input  N_REQ  per-instance single-cycle completion pulse.
REQ-007 SHALL provide port gnt  output  N_REQ  one-hot (or zero) registered grant.
REQ-008 SHALL provide port gnt_id  output  3  binary index of the granted instance; 0 when gnt is zero.
REQ-009 SHALL provide port busy  output  1  high while in GRANT state.
REQ-010 SHALL provide port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-012 IDLE: gnt=0; if any req bit is high, SHALL select the first set bit at or after round-robin pointer ptr (search wraps from N_REQ-1 to 0), load it into gnt/gnt_id at the next edge, clear the hold timer, enter GRANT.
REQ-013 IDLE with req all zero SHALL remain in IDLE, outputs unchanged (zero).
REQ-014 Latency: req asserted in IDLE at cycle N SHALL yield gnt high at cycle N+1.
REQ-015 GRANT: gnt SHALL stay constant and one-hot; the hold timer SHALL increment once per cycle, saturating at TIMEOUT-1.
REQ-016 GRANT SHALL exit to RELEASE on the first of: done[gnt_id]=1, req[gnt_id]=0, or timer==TIMEOUT-1.
REQ-017 done or req changes on non-granted bits SHALL be ignored in GRANT.
REQ-018 If done[gnt_id] and the timeout condition occur in the same cycle, done SHALL take priority and timeout_err SHALL NOT pulse.
REQ-019 RELEASE: gnt=0, gnt_id=0, busy=0 for exactly one cycle; ptr SHALL become (previous gnt_id+1) mod N_REQ (4 wraps to 0); next state IDLE unconditionally.
REQ-020 timeout_err SHALL be high only during the RELEASE cycle following a timeout exit.
REQ-021 Back-to-back grants SHALL show gnt low for exactly two cycles (RELEASE, then IDLE arbitration).
REQ-022 gnt SHALL never have more than one bit set in any cycle.
REQ-023 Timer width SHALL be clog2(TIMEOUT) bits; no wrap-around beyond TIMEOUT-1.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, ptr=0, timer=0, gnt=0, gnt_id=0, busy=0, timeout_err=0.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt immediately without a RELEASE cycle or timeout_err pulse; after release, arbitration SHALL restart from ptr=0.
REQ-026 Deassertion of rst_n SHALL take effect at the next rising clk edge; first arbitration possible in that cycle.

Verification
REQ-027 Reset, then req=5'b10100 -> gnt=5'b00100, gnt_id=2 one cycle later; busy=1.
REQ-028 req=5'b11111 held, each grant ended by done pulse 3 cycles in -> grant order 0,1,2,3,4,0 (wrap), two low-gnt cycles between each.
REQ-029 TIMEOUT=16, req[3] held, no done -> gnt[3] high 16 cycles, then RELEASE with timeout_err=1 for one cycle, ptr=4.
REQ-030 done[gnt_id] on the same cycle timer reaches 15 -> RELEASE with timeout_err=0.
REQ-031 In GRANT to inst 1, pulse done[0] and drop req[4] -> no effect; gnt stays 5'b00010.
REQ-032 rst_n low during GRANT to inst 3 -> gnt=0 same cycle; after reset with req=5'b11111, first grant to inst 0.
